alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports in order: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-002 The request ports SHALL be: req_valid input 1 request present; req_ready output 1 block can accept; req_op input 4 ALU op code; req_a input 18 operand A; req_b input 18 operand B.
REQ-003 The ports toward the downstream ALU SHALL be: alu_sel output 4 op select; alu_a output 18 operand A; alu_b output 18 operand B; alu_c input 18 registered ALU result; alu_lsb input 1 result bit 0; alu_neg input 1 result bit 17.
REQ-004 The response ports SHALL be: rsp_valid output 1 response present; rsp_ready input 1 consumer accepts; rsp_data output 18 result; rsp_lsb output 1 result bit 0; rsp_neg output 1 result bit 17; rsp_err output 1 request rejected; busy output 1 state not IDLE.

Function
REQ-005 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP, all registered on clk.
REQ-006 req_ready SHALL be 1 only in IDLE; a request is accepted on a clk edge with req_valid=1 and req_ready=1.
REQ-007 On acceptance, req_op, req_a and req_b SHALL be latched into internal registers; later req_* changes SHALL have no effect until the next acceptance.
REQ-008 Valid op codes SHALL be 0001..1101; an accepted valid op SHALL move IDLE->ISSUE.
REQ-009 An accepted op of 0000, 1110 or 1111 SHALL move IDLE->RESP with rsp_data=0, rsp_lsb=0, rsp_neg=0, rsp_err=1, and SHALL NOT drive a non-zero alu_sel.
REQ-010 In ISSUE, alu_sel SHALL equal the latched op and alu_a/alu_b the latched operands for exactly one cycle, then the FSM SHALL move to WAIT.
REQ-011 In every state other than ISSUE, alu_sel SHALL be 0000 so the ALU holds its result; alu_a/alu_b SHALL hold the latched operands.
REQ-012 In WAIT, alu_c, alu_lsb and alu_neg SHALL be captured into rsp_data, rsp_lsb and rsp_neg with rsp_err=0, and the FSM SHALL move to RESP.
REQ-013 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_lsb/rsp_neg/rsp_err SHALL be stable until a clk edge with rsp_ready=1, which SHALL move the FSM to IDLE.
REQ-014 rsp_valid SHALL be 0 in IDLE, ISSUE and WAIT; no new request SHALL be accepted in the cycle the response completes; the earliest next acceptance is the following edge.
REQ-015 Latency for a valid op SHALL be 3 cycles: acceptance at edge N gives rsp_valid=1 in the cycle after edge N+2, i.e. ISSUE N+1, WAIT N+2, RESP N+3.
REQ-016 rsp_ready held 1 continuously SHALL give one response per 4 cycles; rsp_ready=0 SHALL stall in RESP indefinitely without changing any rsp_* output.
REQ-017 Result width SHALL be the 18 bits returned by the ALU, with no extension or saturation; wrap-around is as produced by the ALU.
REQ-018 busy SHALL equal (state != IDLE).

Reset
REQ-019 When rst=1 at a clk edge, the FSM SHALL enter IDLE regardless of state, including mid-operation in ISSUE, WAIT or RESP, and any pending response SHALL be discarded.
REQ-020 After reset: req_ready=1, alu_sel=0000, alu_a=0, alu_b=0, rsp_valid=0, rsp_data=0, rsp_lsb=0, rsp_neg=0, rsp_err=0, busy=0, latched op/operands=0.
REQ-021 rst SHALL take priority over req_valid and rsp_ready in the same cycle.

Configuration
REQ-022 Macro ALU_SEQ_DIVZERO_CHECK_EN SHALL control divide-by-zero rejection.
REQ-023 With ALU_SEQ_DIVZERO_CHECK_EN defined, an accepted op 1100 with req_a=0 SHALL be handled as in REQ-009 (IDLE->RESP, rsp_err=1, rsp_data=0, no ALU issue).
REQ-024 Without ALU_SEQ_DIVZERO_CHECK_EN, op 1100 with req_a=0 SHALL be issued normally, and rsp_data SHALL be whatever the ALU returns, with rsp_err=0.

Verification
REQ-025 Send op 1001, a=5, b=7 with rsp_ready=1 -> rsp_valid high 3 cycles after acceptance, rsp_data=12, rsp_lsb=0, rsp_neg=0, rsp_err=0.
REQ-026 Send op 1010, a=1, b=0 -> rsp_data=0x3FFFF, rsp_neg=1, rsp_lsb=1; hold rsp_ready=0 for 5 cycles -> outputs stable and req_ready=0 throughout.
REQ-027 Send op 1111 -> RESP in the next cycle with rsp_err=1 and rsp_data=0; alu_sel stays 0000 in every cycle.
REQ-028 Send op 1100, a=0, b=9 -> with the macro defined, rsp_err=1; without it, alu_sel=1100 for one cycle and rsp_err=0.
REQ-029 Assert rst during WAIT of op 0011 b=4 -> next cycle IDLE, rsp_valid=0, all outputs at reset values, no response delivered.
REQ-030 Back-to-back ops 0011 b=4 then 0110 b=4, req_valid and rsp_ready held 1 -> responses 5 then 3, accepts spaced exactly 4 cycles apart.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Sequences one request at a time through an external registered ALU: ISSUE -> WAIT -> RESP, 3 cycles accept-to-response; illegal ops answer in 1.
// Backpressure: req_ready only in IDLE; RESP holds all rsp_* until rsp_ready. ALU_SEQ_DIVZERO_CHECK_EN rejects op 1100 with a == 0.
module alu_op_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [17:0] req_a,
    input  logic [17:0] req_b,
    output logic [3:0]  alu_sel,
    output logic [17:0] alu_a,
    output logic [17:0] alu_b,
    input  logic [17:0] alu_c,
    input  logic        alu_lsb,
    input  logic        alu_neg,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [17:0] rsp_data,
    output logic        rsp_lsb,
    output logic        rsp_neg,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [17:0] a;
        logic [17:0] b;
    } req_t;

    typedef struct packed {
        logic [17:0] data;
        logic        lsb;
        logic        neg;
        logic        err;
    } rsp_t;

    state_t state;
    state_t state_nxt;
    req_t   lat_q;
    req_t   lat_d;
    rsp_t   rsp_q;
    rsp_t   rsp_d;
    logic   op_bad;
    logic   div_zero;

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    assign div_zero = (req_op == 4'hC) && (req_a == 18'd0);
`else
    assign div_zero = 1'b0;
`endif

    // Ops outside 0001..1101 never reach the ALU; they are answered with an error.
    assign op_bad = (req_op == 4'h0) || (req_op >= 4'hE) || div_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lat_q <= '0;
            rsp_q <= '0;
        end else begin
            state <= state_nxt;
            lat_q <= lat_d;
            rsp_q <= rsp_d;
        end
    end

    always_comb begin
        state_nxt = state;
        lat_d     = lat_q;
        rsp_d     = rsp_q;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    lat_d.op = req_op;
                    lat_d.a  = req_a;
                    lat_d.b  = req_b;
                    if (op_bad) begin
                        rsp_d.data = 18'd0;
                        rsp_d.lsb  = 1'b0;
                        rsp_d.neg  = 1'b0;
                        rsp_d.err  = 1'b1;
                        state_nxt  = RESP;
                    end else begin
                        state_nxt  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                // ALU registered its result at the end of ISSUE.
                rsp_d.data = alu_c;
                rsp_d.lsb  = alu_lsb;
                rsp_d.neg  = alu_neg;
                rsp_d.err  = 1'b0;
                state_nxt  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    // A zero select makes the ALU hold its result outside the single ISSUE cycle.
    assign alu_sel   = (state == ISSUE) ? lat_q.op : 4'h0;
    assign alu_a     = lat_q.a;
    assign alu_b     = lat_q.b;

    assign rsp_data  = rsp_q.data;
    assign rsp_lsb   = rsp_q.lsb;
    assign rsp_neg   = rsp_q.neg;
    assign rsp_err   = rsp_q.err;

    property p_rsp_hold;
        @(posedge clk) disable iff (rst)
            (state == RESP && !rsp_ready) |=> (state == RESP && $stable(rsp_q));
    endproperty
    a_rsp_hold: assert property (p_rsp_hold);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized scoreboard bench for alu_op_sequencer with a behavioural registered ALU in the loop.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [17:0] req_a;
    logic [17:0] req_b;
    logic [3:0]  alu_sel;
    logic [17:0] alu_a;
    logic [17:0] alu_b;
    logic [17:0] alu_c;
    logic        alu_lsb;
    logic        alu_neg;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [17:0] rsp_data;
    logic        rsp_lsb;
    logic        rsp_neg;
    logic        rsp_err;
    logic        busy;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_sel   (alu_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .alu_lsb   (alu_lsb),
        .alu_neg   (alu_neg),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_lsb   (rsp_lsb),
        .rsp_neg   (rsp_neg),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    typedef struct {
        logic [17:0] data;
        logic        lsb;
        logic        neg;
        logic        err;
        int          first_cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          started = 1'b0;
    bit          seen = 1'b0;
    int          issue_cyc = -1;
    logic [3:0]  issue_op;
    logic [17:0] issue_a;
    logic [17:0] issue_b;
    int          rdy_mode = 0;

    function automatic logic [17:0] alu_f(input logic [3:0] op, input logic [17:0] a, input logic [17:0] b);
        case (op)
            4'd1:    return a;
            4'd2:    return b;
            4'd3:    return b + 18'd1;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return b - 18'd1;
            4'd7:    return a ^ b;
            4'd8:    return ~a;
            4'd9:    return a + b;
            4'd10:   return b - a;
            4'd11:   return a - b;
            4'd12:   return (a == 18'd0) ? 18'h3FFFF : b / a;
            4'd13:   return {a[16:0], 1'b0};
            default: return 18'd0;
        endcase
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // External ALU: registers a result when selected, holds it when alu_sel is zero.
    always @(posedge clk) begin
        if (rst) alu_c <= 18'd0;
        else if (alu_sel != 4'd0) alu_c <= alu_f(alu_sel, alu_a, alu_b);
    end
    assign alu_lsb = alu_c[0];
    assign alu_neg = alu_c[17];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            2:       rsp_ready = 1'b0;
            default: ;
        endcase
    end

    // Monitor: checks ALU drive every cycle and responses against the scoreboard head.
    always @(negedge clk) begin
        if (started) begin
            if (cyc == issue_cyc) begin
                check("alu_sel_issue", 32'(alu_sel), 32'(issue_op));
                check("alu_a_issue", 32'(alu_a), 32'(issue_a));
                check("alu_b_issue", 32'(alu_b), 32'(issue_b));
            end else begin
                check("alu_sel_idle", 32'(alu_sel), 32'd0);
            end
            if (rst) begin
                seen = 1'b0;
            end else if (rsp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 data=%0h, expected no response (cycle %0d)", rsp_data, cyc);
                end else begin
                    if (!seen) begin
                        check("rsp_latency", 32'(cyc), 32'(sb[0].first_cyc));
                        seen = 1'b1;
                    end
                    check("rsp_data", 32'(rsp_data), 32'(sb[0].data));
                    check("rsp_lsb", 32'(rsp_lsb), 32'(sb[0].lsb));
                    check("rsp_neg", 32'(rsp_neg), 32'(sb[0].neg));
                    check("rsp_err", 32'(rsp_err), 32'(sb[0].err));
                    if (rsp_ready === 1'b1) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end else if (rsp_valid !== 1'b0) begin
                check("rsp_valid_known", 32'(rsp_valid), 32'd0);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [17:0] a, input logic [17:0] b, output int acc);
        int          waitc;
        bit          err;
        logic [17:0] d;
        waitc     = 0;
        acc       = -1;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        while (acc < 0 && waitc < 50) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                acc = cyc + 1;
                err = (op == 4'd0) || (op >= 4'd14);
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
                if (op == 4'd12 && a == 18'd0) err = 1'b1;
`endif
                if (err) begin
                    sb.push_back('{18'd0, 1'b0, 1'b0, 1'b1, acc});
                end else begin
                    d = alu_f(op, a, b);
                    sb.push_back('{d, d[0], d[17], 1'b0, acc + 2});
                    issue_op  = op;
                    issue_a   = a;
                    issue_b   = b;
                    issue_cyc = acc;
                end
            end else begin
                waitc++;
            end
            @(posedge clk);
            #1;
        end
        if (acc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no acceptance in 50 cycles, expected req_ready (op %0h)", op);
            req_valid = 1'b0;
        end
    endtask

    task automatic drop();
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_a     = 18'($urandom);
        req_b     = 18'($urandom);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            cycles(1);
            k++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending responses, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_alu_sel"}, 32'(alu_sel), 32'd0);
        check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_rsp_lsb"}, 32'(rsp_lsb), 32'd0);
        check({tag, "_rsp_neg"}, 32'(rsp_neg), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          acc;
        int          acc2;
        logic [3:0]  op;
        logic [17:0] a;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_a     = 18'd0;
        req_b     = 18'd0;
        rsp_ready = 1'b0;
        cycles(3);
        check_reset("por");
        rst     = 1'b0;
        started = 1'b1;
        cycles(1);

        // Add: 5 + 7, response three cycles after acceptance.
        send(4'd9, 18'd5, 18'd7, acc);
        drop();
        cycles(2);
        check("add_rsp_valid", 32'(rsp_valid), 32'd1);
        check("add_rsp_data", 32'(rsp_data), 32'd12);
        drain();

        // Subtract to -1 with the consumer stalling for five cycles.
        rdy_mode = 2;
        send(4'd10, 18'd1, 18'd0, acc);
        drop();
        cycles(2);
        for (int i = 0; i < 5; i++) begin
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_rsp_data", 32'(rsp_data), 32'h3FFFF);
            check("stall_rsp_neg", 32'(rsp_neg), 32'd1);
            check("stall_rsp_lsb", 32'(rsp_lsb), 32'd1);
            cycles(1);
        end
        rdy_mode = 0;
        drain();

        // Illegal op answers immediately with an error.
        send(4'd15, 18'h1234, 18'h0042, acc);
        drop();
        check("bad_op_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bad_op_rsp_err", 32'(rsp_err), 32'd1);
        check("bad_op_rsp_data", 32'(rsp_data), 32'd0);
        drain();

        // Divide with zero divisor.
        send(4'd12, 18'd0, 18'd9, acc);
        drop();
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        check("divz_rsp_err", 32'(rsp_err), 32'd1);
        check("divz_alu_sel", 32'(alu_sel), 32'd0);
`else
        check("divz_alu_sel_issue", 32'(alu_sel), 32'hC);
        cycles(1);
        check("divz_alu_sel_after", 32'(alu_sel), 32'd0);
`endif
        drain();

        // Reset while waiting on the ALU discards the response.
        send(4'd3, 18'($urandom), 18'd4, acc);
        drop();
        cycles(1);
        check("wait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        sb.delete();
        issue_cyc = -1;
        check_reset("midrst");
        cycles(6);

        // Reset wins over a simultaneous request and response handshake.
        rdy_mode = 2;
        send(4'd9, 18'd1, 18'd2, acc);
        drop();
        cycles(2);
        rdy_mode  = 3;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op    = 4'd1;
        rst       = 1'b1;
        cycles(1);
        rst = 1'b0;
        drop();
        sb.delete();
        issue_cyc = -1;
        check("prio_busy", 32'(busy), 32'd0);
        check("prio_rsp_valid", 32'(rsp_valid), 32'd0);
        check("prio_alu_a", 32'(alu_a), 32'd0);
        rdy_mode = 0;
        cycles(2);

        // Back-to-back with request and response handshakes held high.
        send(4'd3, 18'($urandom), 18'd4, acc);
        send(4'd6, 18'($urandom), 18'd4, acc2);
        drop();
        check("b2b_spacing", 32'(acc2 - acc), 32'd4);
        drain();

        // Random traffic with random consumer backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 18'($urandom);
            if (op == 4'd12 && $urandom_range(0, 3) == 0) a = 18'd0;
            send(op, a, 18'($urandom), acc);
            if ($urandom_range(0, 1) == 1) begin
                drop();
                cycles($urandom_range(0, 2));
            end
        end
        drop();
        rdy_mode = 0;
        drain();
        cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
